// File: rtl/dmem_responder_if.sv
// Request/response bus between a load/store unit and the data-memory responder.
// Vectors are big-endian numbered: bit 0 is the MSB.
interface dmem_responder_if;
   logic        mem_req;
   logic [0:31] addr_to_mem;
   logic        write_enable_to_mem;
   logic        byte_to_mem;
   logic        half_word_to_mem;
   logic        sign_extend_to_mem;
   logic [0:31] data_to_mem;
   logic [0:31] data_from_mem;
   logic        mem_ready;
   logic        mem_busy;
   logic        misaligned;

   modport master (
      output mem_req, addr_to_mem, write_enable_to_mem, byte_to_mem, half_word_to_mem,
             sign_extend_to_mem, data_to_mem,
      input  data_from_mem, mem_ready, mem_busy, misaligned
   );

   modport slave (
      input  mem_req, addr_to_mem, write_enable_to_mem, byte_to_mem, half_word_to_mem,
             sign_extend_to_mem, data_to_mem,
      output data_from_mem, mem_ready, mem_busy, misaligned
   );
endinterface

// File: rtl/dmem_responder.sv
// Word-organised data memory with a fixed-latency single-outstanding request protocol,
// big-endian byte/halfword lanes and misalignment detection.
module dmem_responder #(
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter int unsigned WAIT_STATES = 2
) (
   input logic            clock,
   input logic            reset,
   dmem_responder_if.slave bus
);
   localparam int unsigned AW = $clog2(DEPTH_WORDS);
   localparam int unsigned IdxLo = 30 - AW;
   localparam logic [3:0] WaitLoad = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

   typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

   state_e      state_q;
   logic [3:0]  cnt_q;
   logic [0:31] addr_q, data_q;
   logic        we_q, byte_q, half_q, sext_q;
   logic        ready_q, busy_q, mis_q;
   logic [0:31] dout_q;

   logic [0:31] mem [DEPTH_WORDS];

   // With WAIT_STATES=0 the response is formed on the accept edge, so it must
   // look at the live request rather than the (not yet loaded) latches.
   logic [0:31]   src_addr, src_data;
   logic          src_we, src_byte, src_half, src_sext;
   logic [AW-1:0] src_idx;
   logic [0:31]   rd_word, load_data, merged, resp_data;
   logic [0:7]    rd_byte;
   logic [0:15]   rd_half;
   logic          src_mis;
   logic          unused_addr;

   always_comb begin
      if (state_q == StIdle) begin
         src_addr = bus.addr_to_mem;
         src_data = bus.data_to_mem;
         src_we   = bus.write_enable_to_mem;
         src_byte = bus.byte_to_mem;
         src_half = bus.half_word_to_mem;
         src_sext = bus.sign_extend_to_mem;
      end else begin
         src_addr = addr_q;
         src_data = data_q;
         src_we   = we_q;
         src_byte = byte_q;
         src_half = half_q;
         src_sext = sext_q;
      end
   end

   assign unused_addr = ^src_addr;
   assign src_idx = src_addr[IdxLo:29];
   assign rd_word = mem[src_idx];
   assign rd_byte = rd_word[{src_addr[30:31], 3'b000} +: 8];
   assign rd_half = rd_word[{src_addr[30], 4'b0000} +: 16];
   assign src_mis = !src_byte && (src_half ? src_addr[31] : (src_addr[30:31] != 2'b00));

   always_comb begin
      load_data = rd_word;
      merged    = src_data;
      if (src_byte) begin
         load_data = {{24{src_sext & rd_byte[0]}}, rd_byte};
         merged    = rd_word;
         merged[{src_addr[30:31], 3'b000} +: 8] = src_data[24:31];
      end else if (src_half) begin
         load_data = {{16{src_sext & rd_half[0]}}, rd_half};
         merged    = rd_word;
         merged[{src_addr[30], 4'b0000} +: 16] = src_data[16:31];
      end
      resp_data = (src_we || src_mis) ? 32'd0 : load_data;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= StIdle;
         cnt_q   <= 4'd0;
         addr_q  <= '0;
         data_q  <= '0;
         we_q    <= 1'b0;
         byte_q  <= 1'b0;
         half_q  <= 1'b0;
         sext_q  <= 1'b0;
         ready_q <= 1'b0;
         busy_q  <= 1'b0;
         mis_q   <= 1'b0;
         dout_q  <= '0;
      end else begin
         ready_q <= 1'b0;
         mis_q   <= 1'b0;
         dout_q  <= '0;
         unique case (state_q)
            StIdle: begin
               if (bus.mem_req) begin
                  addr_q <= bus.addr_to_mem;
                  data_q <= bus.data_to_mem;
                  we_q   <= bus.write_enable_to_mem;
                  byte_q <= bus.byte_to_mem;
                  half_q <= bus.half_word_to_mem;
                  sext_q <= bus.sign_extend_to_mem;
                  cnt_q  <= WaitLoad;
                  busy_q <= 1'b1;
                  if (WAIT_STATES == 0) begin
                     state_q <= StResp;
                     ready_q <= 1'b1;
                     mis_q   <= src_mis;
                     dout_q  <= resp_data;
                  end else begin
                     state_q <= StWait;
                  end
               end
            end
            StWait: begin
               if (cnt_q == 4'd0) begin
                  state_q <= StResp;
                  ready_q <= 1'b1;
                  mis_q   <= src_mis;
                  dout_q  <= resp_data;
               end else begin
                  cnt_q <= cnt_q - 4'd1;
               end
            end
            StResp: begin
               state_q <= StIdle;
               busy_q  <= 1'b0;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   // Store commits on the edge that ends RESP; a reset on that edge aborts it.
   always_ff @(posedge clock) begin
      if (!reset && state_q == StResp && src_we && !src_mis) begin
         mem[src_idx] <= merged;
      end
   end

   assign bus.mem_ready     = ready_q;
   assign bus.mem_busy      = busy_q;
   assign bus.misaligned    = mis_q;
   assign bus.data_from_mem = dout_q;
endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: a WAIT_STATES=2 instance driven from a vector table and
// a WAIT_STATES=0 instance for back-to-back and address aliasing; responses via scoreboards.
module tb_dmem_responder;
   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   dmem_responder_if bus2 ();
   dmem_responder_if bus0 ();

   dmem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(2)) dut2 (
      .clock(clock), .reset(reset), .bus(bus2.slave)
   );
   dmem_responder #(.DEPTH_WORDS(16), .WAIT_STATES(0)) dut0 (
      .clock(clock), .reset(reset), .bus(bus0.slave)
   );

   typedef struct {
      logic [31:0] data;
      logic        mis;
   } exp_t;

   typedef struct {
      logic        we, bt, hw, sx;
      logic [31:0] addr, wdata, data;
      logic        mis;
   } vec_t;

   exp_t q0[$];
   exp_t q2[$];
   int   total = 0;
   int   bad = 0;
   int   rc0 = 0;
   int   rc2 = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input int sel, input logic req, input logic we, input logic bt,
                        input logic hw, input logic sx, input logic [31:0] addr,
                        input logic [31:0] wdata);
      if (sel == 0) begin
         bus0.mem_req = req; bus0.write_enable_to_mem = we; bus0.byte_to_mem = bt;
         bus0.half_word_to_mem = hw; bus0.sign_extend_to_mem = sx;
         bus0.addr_to_mem = addr; bus0.data_to_mem = wdata;
      end else begin
         bus2.mem_req = req; bus2.write_enable_to_mem = we; bus2.byte_to_mem = bt;
         bus2.half_word_to_mem = hw; bus2.sign_extend_to_mem = sx;
         bus2.addr_to_mem = addr; bus2.data_to_mem = wdata;
      end
   endtask

   function automatic logic rdy(input int sel);
      return (sel == 0) ? bus0.mem_ready : bus2.mem_ready;
   endfunction

   function automatic logic busy(input int sel);
      return (sel == 0) ? bus0.mem_busy : bus2.mem_busy;
   endfunction

   task automatic push(input int sel, input logic [31:0] data, input logic mis);
      exp_t e;
      e.data = data;
      e.mis  = mis;
      if (sel == 0) q0.push_back(e);
      else q2.push_back(e);
   endtask

   task automatic apply(input int sel, input vec_t v);
      int cyc;
      @(negedge clock);
      drive(sel, 1'b1, v.we, v.bt, v.hw, v.sx, v.addr, v.wdata);
      push(sel, v.data, v.mis);
      @(negedge clock);
      drive(sel, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
      cyc = 1;
      check("busy_in_flight", 32'(busy(sel)), 32'd1);
      while (rdy(sel) !== 1'b1 && cyc < 20) begin
         @(negedge clock);
         cyc++;
      end
      check("latency", cyc, (sel == 0) ? 32'd1 : 32'd3);
      @(negedge clock);
      check("busy_after", 32'(busy(sel)), 32'd0);
   endtask

   // Scoreboards: every response pops one expectation; idle outputs must be zero.
   always @(negedge clock) begin
      exp_t e;
      if (bus2.mem_ready === 1'b1) begin
         rc2++;
         if (q2.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_ready2: got 1 expected 0 at %0t", $time);
         end else begin
            e = q2.pop_front();
            check("resp_data2", bus2.data_from_mem, e.data);
            check("resp_mis2", 32'(bus2.misaligned), 32'(e.mis));
         end
      end else if (!reset) begin
         check("idle_out2", {bus2.data_from_mem[0:30], bus2.data_from_mem[31] | bus2.misaligned},
               32'd0);
      end
   end

   always @(negedge clock) begin
      exp_t e;
      if (bus0.mem_ready === 1'b1) begin
         rc0++;
         if (q0.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_ready0: got 1 expected 0 at %0t", $time);
         end else begin
            e = q0.pop_front();
            check("resp_data0", bus0.data_from_mem, e.data);
            check("resp_mis0", 32'(bus0.misaligned), 32'(e.mis));
         end
      end
   end

   initial begin
      vec_t vt[16];
      vec_t v;
      int   r;
      //          we    bt    hw    sx    addr      wdata         data          mis
      vt[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h40, 32'h12345678, 32'h00000000, 1'b0};
      vt[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h40, 32'h0,        32'h12345678, 1'b0};
      vt[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h41, 32'h0,        32'h00000034, 1'b0};
      vt[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h41, 32'h000000F0, 32'h00000000, 1'b0};
      vt[4]  = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h41, 32'h0,        32'hFFFFFFF0, 1'b0};
      vt[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h40, 32'h0,        32'h12F05678, 1'b0};
      vt[6]  = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h42, 32'h00008001, 32'h00000000, 1'b0};
      vt[7]  = '{1'b0, 1'b0, 1'b1, 1'b1, 32'h42, 32'h0,        32'hFFFF8001, 1'b0};
      vt[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h42, 32'h0,        32'h00008001, 1'b0};
      vt[9]  = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h40, 32'h0,        32'h12F08001, 1'b0};
      vt[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h42, 32'h0,        32'h00000000, 1'b1};
      vt[11] = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h43, 32'h0000BEEF, 32'h00000000, 1'b1};
      vt[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h40, 32'h0,        32'h12F08001, 1'b0};
      vt[13] = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h40, 32'h0,        32'h00000012, 1'b0};
      vt[14] = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h47, 32'h123456A5, 32'h00000000, 1'b0};
      vt[15] = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h47, 32'h0,        32'hFFFFFFA5, 1'b0};

      drive(0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
      drive(2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h40, 32'd0);
      repeat (2) @(negedge clock);
      check("rst_ready", 32'(bus2.mem_ready), 32'd0);
      check("rst_busy", 32'(bus2.mem_busy), 32'd0);
      check("rst_mis", 32'(bus2.misaligned), 32'd0);
      check("rst_data", bus2.data_from_mem, 32'd0);
      reset = 1'b0;
      drive(2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
      @(negedge clock);
      check("req_in_reset_dropped", 32'(bus2.mem_busy), 32'd0);

      for (int i = 0; i < 16; i++) apply(2, vt[i]);

      // Requests held while busy are dropped.
      r = rc2;
      @(negedge clock);
      drive(2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h40, 32'd0);
      push(2, 32'h12F08001, 1'b0);
      @(negedge clock);
      drive(2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h40, 32'hDEADBEEF);
      @(negedge clock);
      @(negedge clock);
      drive(2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
      repeat (5) @(negedge clock);
      check("single_ready", rc2, r + 1);
      v = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h40, 32'h0, 32'h12F08001, 1'b0};
      apply(2, v);

      // Reset during WAIT of a store aborts it.
      v = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h80, 32'h11112222, 32'h0, 1'b0};
      apply(2, v);
      r = rc2;
      @(negedge clock);
      drive(2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h80, 32'h33334444);
      @(negedge clock);
      drive(2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      check("abort_busy", 32'(bus2.mem_busy), 32'd0);
      repeat (6) @(negedge clock);
      check("abort_no_ready", rc2, r);
      v = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h80, 32'h0, 32'h11112222, 1'b0};
      apply(2, v);

      // Zero wait states: aliasing and back-to-back requests.
      v = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h40, 32'hCAFEF00D, 32'h0, 1'b0};
      apply(0, v);
      v = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h80, 32'h0, 32'hCAFEF00D, 1'b0};
      apply(0, v);
      @(negedge clock);
      drive(0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h81, 32'd0);
      for (int i = 0; i < 3; i++) push(0, 32'h000000FE, 1'b0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clock);
         check("b2b_ready", 32'(bus0.mem_ready), 32'((i % 2) == 0));
      end
      drive(0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);

      repeat (5) @(negedge clock);
      check("q2_drained", q2.size(), 32'd0);
      check("q0_drained", q0.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 1024: number of 32-bit words stored; power of two, 16..65536.
REQ-002 Parameter WAIT_STATES, default 2: extra cycles between request accept and response; 0..15.
REQ-003 clock  input  1  system clock; all state changes on rising edge.
REQ-004 reset  input  1  synchronous, active-high.
REQ-005 mem_req  input  1  request valid; sampled only in IDLE.
REQ-006 addr_to_mem  input  [0:31]  byte address; bit 0 = MSB.
REQ-007 write_enable_to_mem  input  1  1 = store, 0 = load.
REQ-008 byte_to_mem  input  1  byte access.
REQ-009 half_word_to_mem  input  1  halfword access.
REQ-010 sign_extend_to_mem  input  1  sign-extend sub-word load data.
REQ-011 data_to_mem  input  [0:31]  store data; sub-word store data right-justified in bits [24:31] or [16:31].
REQ-012 data_from_mem  output  [0:31]  load result; valid only while mem_ready=1.
REQ-013 mem_ready  output  1  one-cycle response pulse.
REQ-014 mem_busy  output  1  request in flight; new requests ignored.
REQ-015 misaligned  output  1  error flag; valid only with mem_ready.

Function
REQ-016 FSM states: IDLE, WAIT, RESP; reset state IDLE.
REQ-017 IDLE with mem_req=1: latch address, all control bits and data_to_mem; go to WAIT if WAIT_STATES>0, else RESP.
REQ-018 WAIT: down-counter loaded with WAIT_STATES-1 at accept; decrements each cycle; go to RESP the cycle after it reads 0.
REQ-019 RESP: mem_ready=1 for exactly one cycle, then return to IDLE; the earliest next accept is the cycle after RESP.
REQ-020 Latency: request accepted at edge N gives mem_ready high during cycle N+1+WAIT_STATES.
REQ-021 mem_busy=1 in WAIT and RESP, 0 in IDLE; mem_req while busy is dropped, not queued.
REQ-022 Inputs changing after accept do not affect the in-flight access.
REQ-023 Word index = latched addr[bits above 30:31] modulo DEPTH_WORDS; out-of-range addresses wrap silently.
REQ-024 Size priority: byte_to_mem=1 gives byte access regardless of half_word_to_mem; else half_word_to_mem=1 gives halfword; else word.
REQ-025 Big-endian lanes: byte offset 0 maps to word bits [0:7], offset 3 to [24:31]; halfword offset 0 maps to [0:15], offset 2 to [16:31].
REQ-026 Misaligned when halfword and addr[31]=1, or word and addr[30:31]!=0; byte accesses are never misaligned.
REQ-027 Store commits at the RESP-cycle edge, writing only the selected lanes; other lanes are unchanged.
REQ-028 Misaligned store: no lanes written; misaligned=1 with mem_ready.
REQ-029 Load: read word at RESP; selected byte/halfword placed in bits [24:31]/[16:31].
REQ-030 Load upper bits are zero, or copies of bit 24 (byte) or bit 16 (halfword) when sign_extend_to_mem=1; word loads ignore sign_extend_to_mem.
REQ-031 Misaligned load: data_from_mem=0, misaligned=1.
REQ-032 Store response: data_from_mem=0.
REQ-033 Outside RESP: data_from_mem=0, misaligned=0, mem_ready=0.
REQ-034 Store followed immediately by a load to the same word returns the updated data.

Reset
REQ-035 reset=1 forces IDLE and clears the counter and latched request; in the following cycle mem_ready=0, mem_busy=0, misaligned=0 and data_from_mem=0.
REQ-036 Reset in WAIT or RESP aborts the access: no store commits on the reset edge, and no response is issued.
REQ-037 Memory contents are not cleared by reset.
REQ-038 mem_req asserted in the reset cycle is not accepted.

Verification
REQ-039 WAIT_STATES=2: word store 0x12345678 at addr 0x40, then word load at 0x40 -> each mem_ready 3 cycles after accept; load returns 0x12345678, misaligned=0.
REQ-040 Byte loads at 0x41: unsigned -> 0x00000034; after byte store 0xF0 at 0x41, signed byte load -> 0xFFFFFFF0 and word at 0x40 = 0x12F05678.
REQ-041 Halfword store 0x8001 at 0x42, then signed halfword load 0x42 -> 0xFFFF8001; unsigned -> 0x00008001; word at 0x40 = 0x12F08001.
REQ-042 Word load at 0x42 and halfword store at 0x43 -> misaligned=1; load data 0; memory unchanged.
REQ-043 Second mem_req while busy -> ignored, only one mem_ready; reset asserted during WAIT of a store to 0x80 -> no mem_ready; 0x80 retains its old value.
REQ-044 WAIT_STATES=0 back-to-back requests -> mem_ready every second cycle; addr = DEPTH_WORDS*4 + 0x40 aliases to 0x40.
